lcd_win_ctrl: RTL

LCD_WIN_CTRL -- requirements
Module: lcd_win_ctrl

---
 rtl/lcd_win_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lcd_win_ctrl.sv
// rtl/lcd_win_ctrl.sv - windowed readout of a row-major pixel buffer with pan, mirror and home commands
module lcd_win_ctrl #(
    parameter int DW     = 8,
    parameter int IMG_W  = 6,
    parameter int IMG_H  = 6,
    parameter int WIN_W  = 3,
    parameter int WIN_H  = 3,
    parameter int ORG_X0 = 2,
    parameter int ORG_Y0 = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] datain,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int XW   = $clog2(IMG_W + 1);
    localparam int YW   = $clog2(IMG_H + 1);
    localparam int CW   = $clog2(WIN_W + 1);
    localparam int RW   = $clog2(WIN_H + 1);

    localparam logic [XW-1:0] X_HOME = XW'(ORG_X0);
    localparam logic [YW-1:0] Y_HOME = YW'(ORG_Y0);
    localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - WIN_W);
    localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - WIN_H);
    localparam logic [AW-1:0] K_LAST = AW'(NPIX - 1);
    localparam logic [CW-1:0] C_LAST = CW'(WIN_W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(WIN_H - 1);

    localparam logic [2:0] CMD_REFRESH = 3'd0;
    localparam logic [2:0] CMD_LOAD    = 3'd1;
    localparam logic [2:0] CMD_RIGHT   = 3'd2;
    localparam logic [2:0] CMD_LEFT    = 3'd3;
    localparam logic [2:0] CMD_UP      = 3'd4;
    localparam logic [2:0] CMD_DOWN    = 3'd5;
    localparam logic [2:0] CMD_MIRROR  = 3'd6;
    localparam logic [2:0] CMD_HOME    = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_OUT
    } state_t;

    state_t        state;
    logic [2:0]    cmd_q;
    logic [XW-1:0] ox;
    logic [YW-1:0] oy;
    logic          mirror;
    logic [AW-1:0] k;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic [AW-1:0] rd_addr;

    logic [DW-1:0] mem [NPIX];

    // Arithmetic is done at 32 bits; every legal result is below NPIX so the final cast never drops set bits.
    always_comb begin
        rd_addr = '0;
        if (mirror)
            rd_addr = AW'((int'(oy) + int'(r)) * IMG_W + int'(ox) + (WIN_W - 1) - int'(c));
        else
            rd_addr = AW'((int'(oy) + int'(r)) * IMG_W + int'(ox) + int'(c));
    end

    // Buffer contents survive reset; a reset edge only suppresses the pending write.
    always_ff @(posedge clk) begin
        if (!reset && state == S_LOAD)
            mem[k] <= datain;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cmd_q        <= CMD_REFRESH;
            busy         <= 1'b0;
            output_valid <= 1'b0;
            dataout      <= '0;
            ox           <= X_HOME;
            oy           <= Y_HOME;
            mirror       <= 1'b0;
            k            <= '0;
            r            <= '0;
            c            <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    output_valid <= 1'b0;
                    if (cmd_valid) begin
                        busy  <= 1'b1;
                        cmd_q <= cmd;
                        k     <= '0;
                        r     <= '0;
                        c     <= '0;
                        state <= (cmd == CMD_LOAD) ? S_LOAD : S_EXEC;
                    end
                end

                S_LOAD: begin
                    if (k == K_LAST) begin
                        ox     <= X_HOME;
                        oy     <= Y_HOME;
                        mirror <= 1'b0;
                        state  <= S_OUT;
                    end else begin
                        k <= k + AW'(1);
                    end
                end

                S_EXEC: begin
                    case (cmd_q)
                        CMD_RIGHT:  if (ox < X_MAX) ox <= ox + XW'(1);
                        CMD_LEFT:   if (ox != '0)   ox <= ox - XW'(1);
                        CMD_UP:     if (oy != '0)   oy <= oy - YW'(1);
                        CMD_DOWN:   if (oy < Y_MAX) oy <= oy + YW'(1);
                        CMD_MIRROR: mirror <= ~mirror;
                        CMD_HOME: begin
                            ox <= X_HOME;
                            oy <= Y_HOME;
                        end
                        default: ;
                    endcase
                    state <= S_OUT;
                end

                S_OUT: begin
                    dataout      <= mem[rd_addr];
                    output_valid <= 1'b1;
                    if (c == C_LAST) begin
                        c <= '0;
                        if (r == R_LAST) begin
                            // busy drops with the last pixel so IDLE can take a command on the next edge
                            r     <= '0;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            r <= r + RW'(1);
                        end
                    end else begin
                        c <= c + CW'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
